// File: rtl/serializer_fsm.sv
// Parallel-to-serial stage: one word shifting, one word buffered, one bit per
// serial transfer. LSB_FIRST selects the shift direction.
module serializer_fsm #(
    parameter int LENGTH    = 24,
    parameter bit LSB_FIRST = 1'b1
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_en,
    input  logic [LENGTH-1:0] iv_din,
    input  logic              i_din_valid,
    output logic              o_ready,
    output logic              o_dout,
    output logic              o_dout_valid,
    input  logic              i_ready,
    output logic              o_word_done
);
    localparam int            CW   = $clog2(LENGTH) + 1;
    localparam logic [CW-1:0] LAST = CW'(LENGTH - 1);

    // Handshakes: a word moves on an enabled edge with o_ready & i_din_valid;
    // a bit moves on an enabled edge with o_dout_valid & i_ready. Neither
    // valid depends combinationally on the opposite side's ready.
    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SHIFT = 2'b01
    } state_t;

    state_t              state_q, state_d;
    logic [LENGTH-1:0]   buf_q, buf_d;
    logic                buf_full_q, buf_full_d;
    logic [LENGTH-1:0]   shift_q, shift_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic                ready_d, valid_d, done_d;
    logic                xfer, accept;

    function automatic logic [LENGTH-1:0] shift_one(input logic [LENGTH-1:0] v);
        if (LSB_FIRST) return {1'b0, v[LENGTH-1:1]};
        else           return {v[LENGTH-2:0], 1'b0};
    endfunction

    assign xfer   = o_dout_valid & i_ready;
    assign accept = o_ready & i_din_valid;
    assign o_dout = LSB_FIRST ? shift_q[0] : shift_q[LENGTH-1];

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q      <= IDLE;
            buf_q        <= '0;
            buf_full_q   <= 1'b0;
            shift_q      <= '0;
            cnt_q        <= '0;
            o_ready      <= 1'b0;
            o_dout_valid <= 1'b0;
            o_word_done  <= 1'b0;
        end else if (i_en) begin
            state_q      <= state_d;
            buf_q        <= buf_d;
            buf_full_q   <= buf_full_d;
            shift_q      <= shift_d;
            cnt_q        <= cnt_d;
            o_ready      <= ready_d;
            o_dout_valid <= valid_d;
            o_word_done  <= done_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        buf_d      = buf_q;
        buf_full_d = buf_full_q;
        shift_d    = shift_q;
        cnt_d      = cnt_q;
        valid_d    = o_dout_valid;
        done_d     = 1'b0;

        case (state_q)
            IDLE: begin
                valid_d = 1'b0;
                if (buf_full_q) begin
                    shift_d    = buf_q;
                    buf_full_d = 1'b0;
                    cnt_d      = '0;
                    state_d    = SHIFT;
                    valid_d    = 1'b1;
                end
            end
            SHIFT: begin
                valid_d = 1'b1;
                if (xfer) begin
                    shift_d = shift_one(shift_q);
                    cnt_d   = cnt_q + 1'b1;
                    if (cnt_q == LAST) begin
                        done_d = 1'b1;
                        cnt_d  = '0;
                        // A buffered word follows with no gap in the bit stream.
                        if (buf_full_q) begin
                            shift_d    = buf_q;
                            buf_full_d = 1'b0;
                        end else begin
                            state_d = IDLE;
                            valid_d = 1'b0;
                        end
                    end
                end
            end
            default: begin
                state_d = IDLE;
                valid_d = 1'b0;
                cnt_d   = '0;
            end
        endcase

        // o_ready high implies the buffer was empty, so this never races a load.
        if (accept) begin
            buf_d      = iv_din;
            buf_full_d = 1'b1;
        end
        ready_d = ~buf_full_d;
    end
endmodule

// File: tb/tb_serializer_fsm.sv
// Bench for serializer_fsm: directed words, expected serial bits queued at
// issue and popped by a monitor on every observed bit transfer.
module tb_serializer_fsm;
    localparam int L = 24;

    logic         clk        = 1'b0;
    logic         rst        = 1'b1;
    logic         en         = 1'b1;
    logic [L-1:0] din        = '0;
    logic         din_valid  = 1'b0;
    logic         ready      = 1'b1;
    logic [L-1:0] din1       = '0;
    logic         din_valid1 = 1'b0;
    logic         ready1     = 1'b1;

    logic o_ready, o_dout, o_dout_valid, o_word_done;
    logic o_ready1, o_dout1, o_dout_valid1, o_word_done1;

    logic [0:0] exp_q[$];
    logic [0:0] exp1_q[$];
    int         checks  = 0;
    int         errors  = 0;
    int         bit_cnt = 0;
    logic       wd_exp  = 1'b0;

    serializer_fsm #(.LENGTH(L), .LSB_FIRST(1'b1)) dut (
        .i_clk(clk), .i_rst(rst), .i_en(en), .iv_din(din), .i_din_valid(din_valid),
        .o_ready(o_ready), .o_dout(o_dout), .o_dout_valid(o_dout_valid),
        .i_ready(ready), .o_word_done(o_word_done)
    );

    serializer_fsm #(.LENGTH(L), .LSB_FIRST(1'b0)) dut_msb (
        .i_clk(clk), .i_rst(rst), .i_en(en), .iv_din(din1), .i_din_valid(din_valid1),
        .o_ready(o_ready1), .o_dout(o_dout1), .o_dout_valid(o_dout_valid1),
        .i_ready(ready1), .o_word_done(o_word_done1)
    );

    // clock/reset block
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // scoreboard monitor: sampled on the falling edge, it predicts what the
    // next rising edge does and compares the serial bit and o_word_done
    always @(negedge clk) begin
        check("word_done", o_word_done, wd_exp);
        if (rst) begin
            bit_cnt = 0;
            wd_exp  = 1'b0;
        end else if (en) begin
            wd_exp = 1'b0;
            if (o_dout_valid && ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_bit: got %0b, expected no transfer at %0t", o_dout, $time);
                end else begin
                    check("serial_bit", o_dout, exp_q.pop_front());
                end
                wd_exp  = (bit_cnt == L - 1);
                bit_cnt = (bit_cnt == L - 1) ? 0 : bit_cnt + 1;
            end
        end
    end

    always @(negedge clk) begin
        if (!rst && en && o_dout_valid1 && ready1) begin
            if (exp1_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_bit_msb: got %0b, expected no transfer at %0t", o_dout1, $time);
            end else begin
                check("serial_bit_msb", o_dout1, exp1_q.pop_front());
            end
        end
    end

    // driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // seq lists the required serial bits, first-sent bit in the MSB position
    task automatic send_word(input logic [L-1:0] w, input logic [L-1:0] seq);
        int n = 0;
        while (!o_ready && n < 50) begin
            tick();
            n++;
        end
        check("ready_before_accept", o_ready, 1);
        din       = w;
        din_valid = 1'b1;
        for (int i = L - 1; i >= 0; i--) exp_q.push_back(seq[i]);
        tick();
        din_valid = 1'b0;
    endtask

    task automatic drain(input string name);
        int n = 0;
        while (exp_q.size() != 0 && n < 300) begin
            tick();
            n++;
        end
        check(name, exp_q.size(), 0);
    endtask

    task automatic wait_bits(input int remaining);
        int n = 0;
        while (exp_q.size() > remaining && n < 300) begin
            tick();
            n++;
        end
        check("wait_bits", exp_q.size(), remaining);
    endtask

    initial begin
        logic [3:0] bp_pat;
        logic       prev_v, prev_d;
        logic [3:0] snap;
        int         run, n, cyc;

        // reset state
        tick();
        tick();
        check("rst_ready", o_ready, 0);
        check("rst_dout", o_dout, 0);
        check("rst_valid", o_dout_valid, 0);
        check("rst_word_done", o_word_done, 0);
        rst = 1'b0;
        tick();
        check("ready_after_reset", o_ready, 1);

        // single word, sink always ready
        send_word(24'hA50F3C, 24'b0011_1100_1111_0000_1010_0101);
        check("ready_after_accept", o_ready, 0);
        check("valid_on_accept_edge", o_dout_valid, 0);
        tick();
        check("first_bit_latency", o_dout_valid, 1);
        drain("drain_single");
        check("idle_after_single", o_dout_valid, 0);

        // backpressure: i_ready pattern 1,0,0,1 repeating
        send_word(24'hA50F3C, 24'b0011_1100_1111_0000_1010_0101);
        bp_pat = 4'b1001;
        cyc = 0;
        n = 0;
        while (exp_q.size() != 0 && n < 300) begin
            ready  = bp_pat[cyc % 4];
            prev_v = o_dout_valid;
            prev_d = o_dout;
            tick();
            cyc++;
            n++;
            if (prev_v && !ready) check("bp_hold", {o_dout_valid, o_dout}, {1'b1, prev_d});
        end
        check("drain_bp", exp_q.size(), 0);
        ready = 1'b1;
        check("idle_after_bp", o_dout_valid, 0);

        // back-to-back words, 48 contiguous valid bits
        send_word(24'h000001, 24'h800000);
        check("b2b_ready_before_load", o_ready, 0);
        tick();
        run = 0;
        if (o_dout_valid) run++;
        send_word(24'h800000, 24'h000001);
        if (o_dout_valid) run++;
        n = 0;
        while (o_dout_valid && n < 100) begin
            tick();
            n++;
            if (o_dout_valid) run++;
        end
        check("b2b_contiguous_bits", run, 48);
        check("drain_b2b", exp_q.size(), 0);

        // clock enable dropped for 5 cycles after bit 10
        send_word(24'h0F0F0F, 24'hF0F0F0);
        wait_bits(L - 10);
        en   = 1'b0;
        snap = {o_ready, o_dout, o_dout_valid, o_word_done};
        repeat (5) begin
            tick();
            check("en_freeze", {o_ready, o_dout, o_dout_valid, o_word_done}, snap);
        end
        en = 1'b1;
        drain("drain_en");
        check("idle_after_en", o_dout_valid, 0);

        // reset after bit 7 with a second word buffered
        send_word(24'h0000AA, 24'h550000);
        send_word(24'hFFFFFF, 24'hFFFFFF);
        wait_bits(2 * L - 7);
        rst = 1'b1;
        exp_q.delete();
        tick();
        check("midrst_valid", o_dout_valid, 0);
        check("midrst_ready", o_ready, 0);
        rst = 1'b0;
        tick();
        check("midrst_ready_release", o_ready, 1);
        send_word(24'h3C0000, 24'h00003C);
        drain("drain_after_reset");
        check("idle_after_reset_word", o_dout_valid, 0);

        // MSB-first instance
        check("msb_ready", o_ready1, 1);
        din1       = 24'hC00001;
        din_valid1 = 1'b1;
        begin
            logic [L-1:0] seq1;
            seq1 = 24'b1100_0000_0000_0000_0000_0001;
            for (int i = L - 1; i >= 0; i--) exp1_q.push_back(seq1[i]);
        end
        tick();
        din_valid1 = 1'b0;
        n = 0;
        while (exp1_q.size() != 0 && n < 100) begin
            tick();
            n++;
        end
        check("drain_msb", exp1_q.size(), 0);
        check("msb_word_done", o_word_done1, 1);
        check("msb_idle", o_dout_valid1, 0);

        tick();
        tick();
        check("final_queue_empty", exp_q.size(), 0);

        // final report
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/serializer_fsm.md
Name: serializer_fsm

Overview:
Parallel-to-serial stage downstream of the FIR filter. Accepts LENGTH-bit filter output words over a valid/ready handshake and holds one word in a buffer while another is being shifted. Emits one bit per transfer over a per-bit valid/ready handshake to the serial sink (testbench or link). Pairs with the input deserializer so the filter datapath is serial in and serial out.

Parameters:
LENGTH, 24, word width in bits; the bit counter is $clog2(LENGTH)+1 bits wide.
LSB_FIRST, 1, 1 = bit 0 is sent first (shift right); 0 = bit LENGTH-1 is sent first (shift left).

Ports:
i_clk  input  1  clock
i_rst  input  1  synchronous, active-high reset
i_en  input  1  clock enable; when low, all state and outputs hold
iv_din  input  LENGTH  parallel word from the FIR
i_din_valid  input  1  iv_din valid
o_ready  output  1  word buffer empty; the FIR may present a word
o_dout  output  1  serial data bit
o_dout_valid  output  1  o_dout valid
i_ready  input  1  serial sink accepts o_dout this cycle
o_word_done  output  1  one-cycle pulse after the last bit of a word transfers

Behaviour:
- Reset (i_rst high at an edge, regardless of i_en): state=IDLE, buffer empty, counter=0, shifter=0, o_ready=0, o_dout=0, o_dout_valid=0, o_word_done=0. An in-flight word and any buffered word are discarded.
- All updates below occur only at edges where i_en=1 and i_rst=0.
- Word accept: at an edge with o_ready & i_din_valid, iv_din is written to the buffer and buf_full is set.
- o_ready is registered: o_ready <= ~buf_full_next. It is 1 on the first enabled edge after reset and drops on the edge the word is accepted. Only one word is ever accepted per emptying of the buffer.
- Bit transfer: occurs at an edge with o_dout_valid & i_ready. o_dout and o_dout_valid are driven from registers, with o_dout = shifter[0] (LSB_FIRST=1) or shifter[LENGTH-1] (LSB_FIRST=0).
- IDLE state:
  - o_dout_valid=0.
  - If buf_full: load the shifter from the buffer, clear buf_full, set counter=0, go to SHIFT. o_dout_valid=1 from that edge.
  - First-bit latency is 1 cycle after the accept edge, i.e. 2 edges from the accept cycle to the first bit.
- SHIFT state, on each bit transfer:
  - Shift the shifter one position; the vacated bit is filled with 0.
  - counter <= counter+1.
  - Without i_ready, hold the shifter, counter and o_dout stable, and keep o_dout_valid=1.
- Last bit (transfer while counter==LENGTH-1):
  - Assert o_word_done for the next cycle.
  - If buf_full: load the shifter from the buffer, clear buf_full, counter=0, stay in SHIFT. Back-to-back words have no gap.
  - Else: go to IDLE, o_dout_valid<=0, counter<=0.
- Same-edge accept and last bit with the buffer empty: the buffer is written and the state goes to IDLE. The next word starts one cycle later (one-cycle bubble is required).
- i_en low: no accept, no transfer, no state change. o_ready, o_dout, o_dout_valid and o_word_done hold their values. A pending o_word_done pulse extends until the next enabled edge.
- Exactly LENGTH transfers per word. The counter never exceeds LENGTH-1. Unused state encodings recover to IDLE.

Test Plan:
- Single word, LENGTH=24, LSB_FIRST=1: reset, then apply iv_din=24'hA50F3C with i_din_valid=1 and i_ready held 1. Required:
  - o_ready=1 before the accept and 0 after it.
  - First bit valid 1 cycle after the accept edge.
  - 24 consecutive bits 0,0,1,1,1,1,0,0,1,1,1,1,0,0,0,0,1,0,1,0,0,1,0,1.
  - o_word_done pulses once; o_dout_valid=0 afterwards.
- Backpressure: same word with i_ready toggled 1,0,0,1 repeating. Required: o_dout holds during i_ready=0, the bit sequence is identical to the single-word case, and o_word_done pulses only after the 24th accepted bit.
- Back-to-back: words 24'h000001 then 24'h800000, the second accepted while the first is shifting. Required:
  - o_ready=0 until the first word's shifter load.
  - 48 contiguous valid bits with no gap: 1 followed by 23 zeros, then 23 zeros followed by 1.
  - Two o_word_done pulses, 24 cycles apart.
- Clock enable: drop i_en for 5 cycles mid-word (after bit 10). Required: all outputs frozen, no bits lost or duplicated, and 24 bits total.
- Reset mid-word: assert i_rst after bit 7, with a second word buffered. Required:
  - Next cycle: o_dout_valid=0, o_ready=0.
  - After release, o_ready=1.
  - The next word is sent in full; the remains of the old word are never emitted.
- LSB_FIRST=0, word 24'hC00001. Required: bits 1,1, then 21 zeros, then 1.
